// File: rtl/td4_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : td4_prog_loader
// Purpose  : UART program loader and 16x8 instruction memory for the TD4 CPU.
//            It receives a framed program (0xA5 sync, 16 data bytes, 8-bit
//            additive checksum) and writes it into memory. It holds the CPU
//            stopped until a complete frame with a valid checksum has landed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CLK_DIV   clock cycles per UART bit (4..65535)
//   TIMEOUT   max idle clocks between bytes inside a frame (1..2^20-1)
// Ports:
//   clock      in   system clock, rising-edge active
//   reset      in   asynchronous, active-low reset; clears all state
//   uart_rx    in   serial input, 8N1, LSB first, idle high (asynchronous)
//   ip         in   [3:0] CPU instruction pointer
//   instr      out  [7:0] mem[ip], combinational
//   cpu_run    out  high when the CPU may execute
//   load_busy  out  high while a frame is in progress
//   load_err   out  sticky error from the last frame attempt
// ============================================================================
module td4_prog_loader #(
  parameter int CLK_DIV = 434,
  parameter int TIMEOUT = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic [3:0] ip,
  output logic [7:0] instr,
  output logic       cpu_run,
  output logic       load_busy,
  output logic       load_err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLK_DIV / 2) - 1);
  // The timeout fires on the edge where the idle count would reach TIMEOUT.
  localparam logic [19:0] TO_LAST   = 20'(TIMEOUT - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    F_SYNC = 2'd0,
    F_DATA = 2'd1,
    F_SUM  = 2'd2
  } frame_state_t;

  // Synchroniser
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_s;

  // Receiver
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] div_cnt_q,  div_cnt_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic [7:0]  shift_q,    shift_d;
  logic        rx_valid;
  logic        rx_ferr;
  logic [7:0]  rx_byte;

  // Frame handling
  frame_state_t frame_q,     frame_d;
  logic [3:0]   addr_q,      addr_d;
  logic [7:0]   sum_q,       sum_d;
  logic [19:0]  to_cnt_q,    to_cnt_d;
  logic         cpu_run_q,   cpu_run_d;
  logic         load_busy_q, load_busy_d;
  logic         load_err_q,  load_err_d;
  logic         timeout_hit;
  logic         frame_abort;

  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];

  assign sync1_d = uart_rx;
  assign sync2_d = sync1_q;
  assign rx_s    = sync2_q;
  assign rx_byte = shift_q;

  // --------------------------------------------------------------------------
  // Receiver next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    div_cnt_d  = div_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        div_cnt_d = '0;
        if (!rx_s) rx_state_d = R_START;
      end
      R_START: begin
        if (div_cnt_q == HALF_LAST) begin
          div_cnt_d  = '0;
          bit_idx_d  = '0;
          // A line back high at mid-start-bit is treated as a glitch.
          rx_state_d = rx_s ? R_IDLE : R_DATA;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      R_DATA: begin
        if (div_cnt_q == BIT_LAST) begin
          div_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      R_STOP: begin
        if (div_cnt_q == BIT_LAST) begin
          div_cnt_d  = '0;
          rx_valid   = rx_s;
          rx_ferr    = ~rx_s;
          rx_state_d = R_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame next-state logic
  // --------------------------------------------------------------------------
  // The inter-byte timer only advances while a frame is open and the receiver
  // is waiting for a start bit.
  assign timeout_hit = (frame_q != F_SYNC) && (rx_state_q == R_IDLE) &&
                       (to_cnt_q == TO_LAST);
  assign frame_abort = rx_ferr || timeout_hit;

  always_comb begin
    frame_d     = frame_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    cpu_run_d   = cpu_run_q;
    load_busy_d = load_busy_q;
    load_err_d  = load_err_q;
    mem_d       = mem_q;

    if ((frame_q == F_SYNC) || (rx_state_q != R_IDLE) || rx_valid)
      to_cnt_d = '0;
    else
      to_cnt_d = to_cnt_q + 20'd1;

    case (frame_q)
      F_SYNC: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          // Stop the CPU on the same edge so it never fetches a half-written
          // program.
          cpu_run_d   = 1'b0;
          load_busy_d = 1'b1;
          load_err_d  = 1'b0;
          addr_d      = '0;
          sum_d       = '0;
          frame_d     = F_DATA;
        end
      end
      F_DATA: begin
        if (rx_valid) begin
          mem_d[addr_q] = rx_byte;
          sum_d         = sum_q + rx_byte;
          if (addr_q == 4'd15) frame_d = F_SUM;
          else                 addr_d  = addr_q + 4'd1;
        end else if (frame_abort) begin
          load_err_d  = 1'b1;
          load_busy_d = 1'b0;
          cpu_run_d   = 1'b0;
          frame_d     = F_SYNC;
        end
      end
      F_SUM: begin
        if (rx_valid) begin
          if (rx_byte == sum_q) cpu_run_d  = 1'b1;
          else                  load_err_d = 1'b1;
          load_busy_d = 1'b0;
          frame_d     = F_SYNC;
        end else if (frame_abort) begin
          load_err_d  = 1'b1;
          load_busy_d = 1'b0;
          cpu_run_d   = 1'b0;
          frame_d     = F_SYNC;
        end
      end
      default: frame_d = F_SYNC;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_state_q  <= R_IDLE;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_q     <= F_SYNC;
      addr_q      <= '0;
      sum_q       <= '0;
      to_cnt_q    <= '0;
      cpu_run_q   <= 1'b0;
      load_busy_q <= 1'b0;
      load_err_q  <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_state_q  <= rx_state_d;
      div_cnt_q   <= div_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_q     <= frame_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      to_cnt_q    <= to_cnt_d;
      cpu_run_q   <= cpu_run_d;
      load_busy_q <= load_busy_d;
      load_err_q  <= load_err_d;
      for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign instr     = mem_q[ip];
  assign cpu_run   = cpu_run_q;
  assign load_busy = load_busy_q;
  assign load_err  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_td4_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_prog_loader
// Purpose  : Self-checking bench for td4_prog_loader. A UART driver sends
//            frames; every byte sent with a good stop bit is queued and the
//            receiver output is checked against the queue. Memory contents are
//            queued per sweep and popped as ip is stepped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_td4_prog_loader;

  localparam int CLK_DIV = 8;
  localparam int TIMEOUT = 200;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       uart_rx = 1'b1;
  logic [3:0] ip      = 4'd0;
  logic [7:0] instr;
  logic       cpu_run;
  logic       load_busy;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_exp_q [$];
  logic [7:0] mem_exp_q [$];
  logic [7:0] mon_exp;

  td4_prog_loader #(
    .CLK_DIV (CLK_DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .ip        (ip),
    .instr     (instr),
    .cpu_run   (cpu_run),
    .load_busy (load_busy),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  // Receiver scoreboard: each received byte must match the oldest byte sent.
  always @(negedge clock) begin
    if (dut.rx_valid) begin
      checks = checks + 1;
      if (rx_exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rx_byte: got %02h, expected no byte", dut.rx_byte);
      end else begin
        mon_exp = rx_exp_q.pop_front();
        if (dut.rx_byte !== mon_exp) begin
          errors = errors + 1;
          $display("FAIL rx_byte: got %02h, expected %02h", dut.rx_byte, mon_exp);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) rx_exp_q.push_back(b);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clock);
    end
    uart_rx = stop_ok;
    repeat (CLK_DIV) @(negedge clock);
    uart_rx = 1'b1;
    if (!stop_ok) repeat (2 * CLK_DIV) @(negedge clock);
  endtask

  task automatic wait_rv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 * CLK_DIV; i++) begin
      @(negedge clock);
      if (dut.rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Sends 16 data bytes (base, or base+i when inc) and returns their sum.
  task automatic send_payload(input logic [7:0] base, input bit inc,
                              output logic [7:0] sum);
    logic [7:0] b;
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      b   = inc ? base + 8'(i) : base;
      sum = sum + b;
      send_byte(b, 1'b1);
    end
  endtask

  task automatic check_mem(input logic [7:0] base, input bit inc, input string name);
    logic [7:0] e;
    for (int i = 0; i < 16; i++) mem_exp_q.push_back(inc ? base + 8'(i) : base);
    for (int i = 0; i < 16; i++) begin
      ip = 4'(i);
      #1;
      e = mem_exp_q.pop_front();
      checks = checks + 1;
      if (instr !== e) begin
        errors = errors + 1;
        $display("FAIL %s: instr[%0d] got %02h, expected %02h", name, i, instr, e);
      end
    end
  endtask

  task automatic check_flags(input logic run, input logic busy, input logic err,
                             input string name);
    checks = checks + 1;
    if ({cpu_run, load_busy, load_err} !== {run, busy, err}) begin
      errors = errors + 1;
      $display("FAIL %s: run/busy/err got %b%b%b, expected %b%b%b",
               name, cpu_run, load_busy, load_err, run, busy, err);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check_flags(1'b0, 1'b0, 1'b0, "reset_flags");
    check_mem(8'h00, 1'b0, "reset_mem");
  endtask

  // Good frame: 0x00..0x0F, checksum 0x78; cpu_run rises one clock after the
  // checksum byte is received.
  task automatic test_good_load();
    logic [7:0] sum;
    bit ok;
    send_byte(8'hA5, 1'b1);
    check_flags(1'b0, 1'b1, 1'b0, "good_after_sync");
    send_payload(8'h00, 1'b1, sum);
    fork
      send_byte(8'h78, 1'b1);
      begin
        wait_rv(ok);
        checks = checks + 1;
        if (!ok) begin
          errors = errors + 1;
          $display("FAIL good_chk_rx: got no byte, expected checksum byte");
        end
        check_flags(1'b0, 1'b1, 1'b0, "good_at_chk_rv");
        @(negedge clock);
        check_flags(1'b1, 1'b0, 1'b0, "good_after_chk");
      end
    join
    check_mem(8'h00, 1'b1, "good_mem");
  endtask

  task automatic test_bad_checksum();
    logic [7:0] sum;
    send_byte(8'hA5, 1'b1);
    check_flags(1'b0, 1'b1, 1'b0, "bad_after_sync");
    send_payload(8'h00, 1'b1, sum);
    send_byte(8'h79, 1'b1);
    check_flags(1'b0, 1'b0, 1'b1, "bad_chk_flags");
    check_mem(8'h00, 1'b1, "bad_chk_mem");
  endtask

  task automatic test_reload();
    logic [7:0] sum;
    bit ok;
    send_byte(8'hA5, 1'b1);
    send_payload(8'h00, 1'b1, sum);
    send_byte(8'h78, 1'b1);
    check_flags(1'b1, 1'b0, 1'b0, "reload_first_run");
    fork
      send_byte(8'hA5, 1'b1);
      begin
        wait_rv(ok);
        checks = checks + 1;
        if (!ok) begin
          errors = errors + 1;
          $display("FAIL reload_sync_rx: got no byte, expected sync byte");
        end
        check_flags(1'b1, 1'b0, 1'b0, "reload_at_sync_rv");
        @(negedge clock);
        check_flags(1'b0, 1'b1, 1'b0, "reload_after_sync");
      end
    join
    send_payload(8'hB7, 1'b0, sum);
    send_byte(8'h70, 1'b1);
    check_flags(1'b1, 1'b0, 1'b0, "reload_done");
    check_mem(8'hB7, 1'b0, "reload_mem");
  endtask

  task automatic test_ferr_glitch();
    logic [7:0] sum;
    logic [7:0] e;
    // Short low pulse while idle: must not produce a byte or change state.
    uart_rx = 1'b0;
    repeat (2) @(negedge clock);
    uart_rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clock);
    check_flags(1'b1, 1'b0, 1'b0, "glitch_flags");
    check_mem(8'hB7, 1'b0, "glitch_mem");

    // Data byte 5 (sixth payload byte) with a low stop bit.
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i), 1'b1);
    send_byte(8'h25, 1'b0);
    check_flags(1'b0, 1'b0, 1'b1, "ferr_flags");
    for (int i = 0; i < 16; i++) mem_exp_q.push_back(i < 5 ? 8'h20 + 8'(i) : 8'hB7);
    for (int i = 0; i < 16; i++) begin
      ip = 4'(i);
      #1;
      e = mem_exp_q.pop_front();
      checks = checks + 1;
      if (instr !== e) begin
        errors = errors + 1;
        $display("FAIL ferr_mem: instr[%0d] got %02h, expected %02h", i, instr, e);
      end
    end

    // FSM must be back in sync hunting: a full frame loads normally.
    send_byte(8'hA5, 1'b1);
    send_payload(8'h30, 1'b1, sum);
    send_byte(sum, 1'b1);
    check_flags(1'b1, 1'b0, 1'b0, "ferr_recover_flags");
    check_mem(8'h30, 1'b1, "ferr_recover_mem");
  endtask

  task automatic test_timeout();
    bit ok;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    fork
      send_byte(8'h43, 1'b1);
      begin
        wait_rv(ok);
        checks = checks + 1;
        if (!ok) begin
          errors = errors + 1;
          $display("FAIL timeout_rx: got no byte, expected data byte");
        end
        repeat (TIMEOUT) @(negedge clock);
        check_flags(1'b0, 1'b1, 1'b0, "timeout_before");
        @(negedge clock);
        check_flags(1'b0, 1'b0, 1'b1, "timeout_at");
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check_flags(1'b0, 1'b1, 1'b0, "midreset_busy");
    #2;
    reset = 1'b0;
    #1;
    check_flags(1'b0, 1'b0, 1'b0, "midreset_flags");
    check_mem(8'h00, 1'b0, "midreset_mem");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_reload();
    test_ferr_glitch();
    test_timeout();
    test_reset_mid_frame();
    checks = checks + 1;
    if (rx_exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL rx_pending: got %0d bytes not received, expected 0", rx_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/td4_prog_loader.md
# td4_prog_loader

UART program loader and instruction memory for the TD4 4-bit CPU. It sits directly upstream of the CPU core. It receives a framed 16-byte program over a serial line and stores it in a 16x8 instruction memory. The CPU reads that memory combinationally through its 4-bit instruction pointer. The loader holds the CPU stopped (`cpu_run` low) until a complete frame with a valid checksum has been written.

## Interface
Parameters:
- `CLK_DIV`, 434: clock cycles per UART bit; legal range 4..65535.
- `TIMEOUT`, 65535: maximum idle clocks between bytes inside a frame; legal range 1..2^20-1.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `uart_rx`  in  1  serial input, 8N1, LSB first, idle high; asynchronous to `clock`.
- `ip`  in  4  CPU instruction pointer.
- `instr`  out  8  instruction byte `mem[ip]`; combinational from `ip` and memory.
- `cpu_run`  out  1  high = CPU may execute; the top level drives the CPU reset with `reset & cpu_run`.
- `load_busy`  out  1  high while a frame is in progress.
- `load_err`  out  1  sticky error from the last frame attempt.

## Operation
- **Input synchroniser:** `uart_rx` passes through 2 flops (reset value 1). All receiver logic uses the synchronised bit.
- **Receiver FSM:**
  - States: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE goes to R_START on a synchronised low.
  - R_START waits CLK_DIV/2 (integer division) clocks, then re-samples the line. Low goes to R_DATA. High counts as a glitch and returns to R_IDLE with no byte produced.
  - R_DATA samples 8 bits, one every CLK_DIV clocks, shifting them in LSB first.
  - R_STOP samples once after CLK_DIV clocks.
    - High: a one-cycle internal `rx_valid` with `rx_byte`.
    - Low: a one-cycle `rx_ferr`.
    - Either way the FSM returns to R_IDLE.
- **Frame FSM:**
  - States: F_SYNC, F_DATA, F_SUM.
  - F_SYNC: `rx_valid` with byte 0xA5 does all of the following on the same edge: sets `cpu_run`=0 and `load_busy`=1, clears `load_err`, `addr`=0 and `sum`=0, then goes to F_DATA. Any other byte is ignored.
  - F_DATA: each `rx_valid` writes `mem[addr]` and adds the byte to `sum` (8-bit, modulo 256). 0xA5 here is ordinary data. At `addr`=15 the FSM goes to F_SUM; otherwise `addr` increments.
  - F_SUM: `rx_valid` with byte == `sum` sets `cpu_run`=1. Any other byte sets `load_err`=1 and leaves `cpu_run`=0. Both cases clear `load_busy` and return to F_SYNC.
- **Frame errors:** in F_DATA or F_SUM, `rx_ferr` or a timeout sets `load_err`=1, clears `load_busy`, keeps `cpu_run`=0 and returns to F_SYNC. Bytes already written are kept.
- **Timeout counter:** runs only in F_DATA and F_SUM while the receiver is in R_IDLE. It clears on every `rx_valid` and on leaving R_IDLE. Expiry occurs when the count reaches TIMEOUT.
- **Framing error in F_SYNC:** ignored.
- **Reset values:**
  - All 16 `mem` entries 0x00, so `instr`=0x00.
  - `cpu_run`=0, `load_busy`=0, `load_err`=0.
  - FSMs in R_IDLE and F_SYNC; `addr`=0, `sum`=0, counters 0.
- **Reset mid-frame:** aborts immediately to the reset values, including a cleared memory.

## Timing
- Synchroniser latency is 2 clocks.
- `rx_valid` fires about 9.5·CLK_DIV + 3 clocks after the start-bit falling edge.
- Memory write, `cpu_run`, `load_busy` and `load_err` are all registered. Each becomes visible on the edge after its `rx_valid`, `rx_ferr` or timeout cycle.
- `instr` has zero-cycle latency from `ip` or a memory write.
- `cpu_run` falls on the edge that accepts a sync byte, so the CPU stops before any memory entry changes.
- A new start bit may begin in the clock immediately after the R_STOP sample; back-to-back bytes are supported.
- Minimum full-frame time is 18 bytes × 10·CLK_DIV clocks.

## Test plan
- **Reset values:** assert reset, release, sweep `ip` 0..15 → `instr`=0x00 for every `ip`; `cpu_run`=0, `load_busy`=0, `load_err`=0.
- **Good load:** CLK_DIV=8; send 0xA5, then 0x00..0x0F, then 0x78 → `load_busy`=1 after the sync byte, `cpu_run`=1 one clock after the checksum `rx_valid`, `instr`==`ip` for all 16 values of `ip`, `load_err`=0.
- **Bad checksum:** same frame but checksum 0x79 → `cpu_run`=0, `load_err`=1, `load_busy`=0, memory holds 0x00..0x0F.
- **Reload while running:** after a good load, send 0xA5 → `cpu_run`=0 the edge after that byte's `rx_valid`; then send a 17-byte payload of sixteen 0xB7 followed by checksum 0x70 → `cpu_run`=1 and every `instr`=0xB7.
- **Framing error and glitch:**
  - Stop bit forced low on data byte 5 → `load_err`=1, `cpu_run`=0, FSM back in F_SYNC (a following good frame loads correctly).
  - A 2-clock low pulse on `uart_rx` while idle → no byte produced and no state change.
- **Timeout:** TIMEOUT=200; send sync plus 3 data bytes, then hold the line idle → `load_err`=1 and `load_busy`=0 exactly TIMEOUT clocks after the last `rx_valid`.
